// File: rtl/event_arbiter_rr_pkg.sv
// Shared encodings for the round-robin event arbiter: FSM states and edge-type values.
package event_arbiter_rr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

endpackage

// File: rtl/event_arbiter_rr_edge_sync_cell.sv
// One event channel: multi-flop synchronizer plus a previous-level flop.
// Produces single-cycle rise/fall pulses from the synchronized level.
module edge_sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_Data,
  output logic o_Rise,
  output logic o_Fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_Data};
      r_prev <= w_level;
    end
  end

  assign o_Rise = w_level & ~r_prev;
  assign o_Fall = ~w_level & r_prev;

endmodule

// File: rtl/event_arbiter_rr.sv
// Multi-channel edge-event scheduler: latches per-channel events as pending and offers
// them one at a time over valid/ready, picking channels round-robin.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | nothing offered; picks next pending channel at/after ptr
//  ST_OFFER | o_Valid high, id/edge held until the consumer takes it
module event_arbiter_rr
  import event_arbiter_rr_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_CH-1:0]          i_Data,
  input  logic [N_CH-1:0]          i_Rise_En,
  input  logic [N_CH-1:0]          i_Fall_En,
  output logic                     o_Valid,
  output logic [$clog2(N_CH)-1:0]  o_Ch_Id,
  output logic                     o_Edge,
  input  logic                     i_Ready,
  output logic [N_CH-1:0]          o_Pending,
  output logic [N_CH-1:0]          o_Overflow,
  input  logic [N_CH-1:0]          i_Clr_Ovf
);

  localparam int IDW = $clog2(N_CH);

  logic [N_CH-1:0]   w_rise, w_fall, w_evt;
  logic [N_CH-1:0]   r_pend, r_etype, r_ovf;
  logic [N_CH-1:0]   w_pend_nxt, w_etype_nxt, w_ovf_nxt, w_ovf_set;
  logic [N_CH-1:0]   w_consume;
  logic [2*N_CH-1:0] w_dbl;
  logic [N_CH-1:0]   w_rot;
  logic [IDW-1:0]    w_off, w_sel, w_ptr_inc;
  logic [IDW:0]      w_sum, w_inc;
  logic              w_hs;

  state_t            r_state, w_state_nxt;
  logic [IDW-1:0]    r_ptr, w_ptr_nxt;
  logic              r_valid, w_valid_nxt;
  logic [IDW-1:0]    r_ch_id, w_ch_id_nxt;
  logic              r_edge, w_edge_nxt;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    edge_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .i_Data  (i_Data[g]),
      .o_Rise  (w_rise[g]),
      .o_Fall  (w_fall[g])
    );
  end

  assign w_evt     = (w_rise & i_Rise_En) | (w_fall & i_Fall_En);
  assign w_hs      = (r_state == ST_OFFER) & i_Ready;
  assign w_consume = w_hs ? (N_CH'(1) << r_ch_id) : '0;

  // A new event on a channel being consumed this cycle replaces it rather than overflowing
  always_comb begin
    w_pend_nxt  = r_pend & ~w_consume;
    w_etype_nxt = r_etype;
    w_ovf_set   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_evt[i]) begin
        if (r_pend[i] & ~w_consume[i]) begin
          w_ovf_set[i] = 1'b1;
        end else begin
          w_pend_nxt[i]  = 1'b1;
          w_etype_nxt[i] = (w_rise[i] & i_Rise_En[i]) ? EDGE_RISE : EDGE_FALL;
        end
      end
    end
    w_ovf_nxt = (r_ovf & ~i_Clr_Ovf) | w_ovf_set;
  end

  assign w_dbl = {r_pend, r_pend};
  assign w_rot = w_dbl[r_ptr +: N_CH];

  always_comb begin
    w_off = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDW'(i);
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sel     = (w_sum >= (IDW+1)'(N_CH)) ? IDW'(w_sum - (IDW+1)'(N_CH)) : IDW'(w_sum);
  assign w_inc     = {1'b0, r_ch_id} + (IDW+1)'(1);
  assign w_ptr_inc = (w_inc == (IDW+1)'(N_CH)) ? '0 : IDW'(w_inc);

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_ch_id_nxt = r_ch_id;
    w_edge_nxt  = r_edge;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (|r_pend) begin
          w_ch_id_nxt = w_sel;
          w_edge_nxt  = r_etype[w_sel];
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (i_Ready) begin
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_ch_id <= '0;
      r_edge  <= 1'b0;
      r_ptr   <= '0;
      r_pend  <= '0;
      r_etype <= '0;
      r_ovf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_ch_id <= w_ch_id_nxt;
      r_edge  <= w_edge_nxt;
      r_ptr   <= w_ptr_nxt;
      r_pend  <= w_pend_nxt;
      r_etype <= w_etype_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign o_Valid    = r_valid;
  assign o_Ch_Id    = r_ch_id;
  assign o_Edge     = r_edge;
  assign o_Pending  = r_pend;
  assign o_Overflow = r_ovf;

endmodule
